// File: rtl/axi_slice_pkg.sv
// Shared types and helpers for the multi-mode AXI channel slice.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS,
    SLICE_FWD,
    SLICE_SPILL,
    SLICE_FIFO
  } slice_mode_e;

  localparam int unsigned SLICE_MIN_FIFO_DEPTH = 2;

  // Width needed to count 0..depth stored beats (never narrower than for depth 2).
  function automatic int unsigned slice_usage_w(input int unsigned depth);
    int unsigned d;
    d = (depth > SLICE_MIN_FIFO_DEPTH) ? depth : SLICE_MIN_FIFO_DEPTH;
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/axi_slice_spill_reg.sv
// Two-entry spill register: A drives the output, B catches the beat that
// arrives while A stalls, so ready_o depends only on local state.
module axi_slice_spill_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            usage_o
);

  logic                  a_full_q, b_full_q;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
  logic                  push, pop;

  assign ready_o = ~b_full_q & ~flush_i;
  assign valid_o = a_full_q & ~flush_i;
  assign data_o  = a_data_q;
  assign usage_o = {1'b0, a_full_q} + {1'b0, b_full_q};
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would let A see B's post-edge content.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else if (flush_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else if (!a_full_q || pop) begin
      if (b_full_q) begin
        a_full_q <= 1'b1;
        a_data_q <= b_data_q;
        b_full_q <= push;
        if (push) b_data_q <= data_i;
      end else begin
        a_full_q <= push;
        if (push) a_data_q <= data_i;
      end
    end else if (push) begin
      b_full_q <= 1'b1;
      b_data_q <= data_i;
    end
  end

endmodule

// File: rtl/axi_multi_mode_slice.sv
// Valid/ready channel slice with selectable timing cut: bypass, forward
// register, spill register or FIFO, plus synchronous flush and occupancy.
module axi_multi_mode_slice
  import axi_slice_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter slice_mode_e MODE       = SLICE_FIFO,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned USAGE_W   = slice_usage_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  testmode_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [USAGE_W-1:0]    usage_o
);

  // Reserved for clock gating; intentionally has no functional effect.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  case (MODE)
    SLICE_BYPASS: begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign valid_o = valid_i & ~flush_i;
      assign ready_o = ready_i & ~flush_i;
      assign data_o  = data_i;
      assign usage_o = '0;
    end

    SLICE_FWD: begin : g_fwd
      logic                  full_q;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  push, pop;

      assign ready_o = (~full_q | ready_i) & ~flush_i;
      assign valid_o = full_q & ~flush_i;
      assign data_o  = data_q;
      assign usage_o = USAGE_W'(full_q);
      assign push    = valid_i & ready_o;
      assign pop     = valid_o & ready_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else if (flush_i) begin
          full_q <= 1'b0;
        end else if (push) begin
          full_q <= 1'b1;
          data_q <= data_i;
        end else if (pop) begin
          full_q <= 1'b0;
        end
      end
    end

    SLICE_SPILL: begin : g_spill
      logic [1:0] spill_usage;

      axi_slice_spill_reg #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_spill (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .usage_o(spill_usage)
      );

      assign usage_o = USAGE_W'(spill_usage);
    end

    default: begin : g_fifo
      if (DEPTH < SLICE_MIN_FIFO_DEPTH) begin : g_depth_check
        $fatal(1, "axi_multi_mode_slice: FIFO DEPTH must be >= 2");
      end

      localparam int unsigned          PTR_W    = $clog2(DEPTH);
      localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
      localparam logic [USAGE_W-1:0]   FULL_CNT = USAGE_W'(DEPTH);

      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
      logic [USAGE_W-1:0]    count_q;
      logic                  full, empty, push, pop;

      assign full    = (count_q == FULL_CNT);
      assign empty   = (count_q == '0);
      assign ready_o = ~full & ~flush_i;
      assign valid_o = ~empty & ~flush_i;
      assign data_o  = empty ? '0 : mem[rd_ptr_q];
      assign usage_o = count_q;
      assign push    = valid_i & ready_o;
      assign pop     = valid_o & ready_i;

      // NOTE: the storage array has no reset; it is only ever read behind
      // count_q, and leaving it out keeps it mappable to plain RAM/flops.
      always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= data_i;
      end

      // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
        end else if (flush_i) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
          if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
          if (push && !pop)      count_q <= count_q + USAGE_W'(1);
          else if (!push && pop) count_q <= count_q - USAGE_W'(1);
        end
      end
    end
  endcase

endmodule

// File: doc/axi_multi_mode_slice.md
Name: axi_multi_mode_slice

Overview:
- Parametrised next-generation AXI channel slice: one valid/ready channel, four selectable timing-cut modes (bypass, forward register, spill register, FIFO).
- Adds synchronous flush and occupancy output.
- Instantiated once per AXI channel (AW/W/B/AR/R) inside slice wrappers and interconnect boundaries to cut combinational paths or absorb bursts.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1)
- MODE, SLICE_FIFO, slice_mode_e: SLICE_BYPASS / SLICE_FWD / SLICE_SPILL / SLICE_FIFO
- DEPTH, 4, FIFO entries; used only in SLICE_FIFO, must be >=2 (elaboration assertion)
- USAGE_W, derived localparam, $clog2(max(DEPTH,2)+1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- testmode_i  in  1  test mode; no functional effect, reserved for clock gating
- flush_i  in  1  synchronous flush; drops all stored beats
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_i  in  DATA_WIDTH  upstream payload
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- data_o  out  DATA_WIDTH  downstream payload
- usage_o  out  USAGE_W  number of stored beats

Behaviour:
- Handshake: a beat transfers on a port when valid & ready are both high at the rising edge.
- Protocol guarantees on the output: once valid_o is high it holds with data_o stable until ready_i. Beats are never dropped, duplicated or reordered, except by flush.
- Reset (async assert, sync release):
  - All storage empty; valid_o=0, data_o=0, usage_o=0.
  - ready_o=1 in FWD/SPILL/FIFO.
- Flush (registered modes):
  - Every entry is cleared at the edge where flush_i=1.
  - While flush_i=1, ready_o=0 and valid_o=0, so no handshake completes in the flush cycle.
  - Flush has priority over simultaneous push/pop.
- SLICE_BYPASS: purely combinational.
  - valid_o=valid_i&~flush_i, ready_o=ready_i&~flush_i, data_o=data_i, usage_o=0.
- SLICE_FWD: one register, cuts the valid/data path only.
  - ready_o=~full_q|ready_i (combinational from ready_i).
  - Latency 1; full throughput.
  - usage_o ranges 0..1.
- SLICE_SPILL: two registers A (output) and B (spill); cuts valid, data and ready paths.
  - ready_o=~b_full_q (fully registered).
  - Data path, per cycle:
    - A empty or popped: push goes to A (from B first if B is full, B then takes the push).
    - A full and not popped: push goes to B.
  - Latency 1; full throughput in steady state.
  - usage_o ranges 0..2.
- SLICE_FIFO: circular buffer of DEPTH entries, no fall-through.
  - Pointers and counters:
    - Read/write pointers wrap DEPTH-1 -> 0, including non-power-of-two DEPTH.
    - Separate count register drives usage_o.
  - Handshake and latency:
    - ready_o=~full (count==DEPTH); valid_o=~empty.
    - Latency 1: a beat pushed into an empty FIFO appears on valid_o the next cycle.
  - Simultaneous push and pop:
    - Not full: count unchanged, both pointers advance.
    - Full: push is refused because ready_o=0; only the pop occurs.
  - data_o is driven from the read-pointer entry. Storage is not reset; data_o is masked to 0 while empty.
- Reset mid-transfer: all in-flight beats are discarded; the upstream must reissue.

Decomposition:
- axi_slice_pkg holds:
  - slice_mode_e enum
  - function slice_usage_w(depth) returning USAGE_W
  - SLICE_MIN_FIFO_DEPTH=2
- Sub-module axi_slice_spill_reg (A/B spill register, DATA_WIDTH param) implements SLICE_SPILL.
- FWD and FIFO are generated inline in axi_multi_mode_slice via a generate case on MODE.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with valid_i=1 -> valid_o=0, usage_o=0, data_o=0. After release (FWD/SPILL/FIFO) ready_o=1.
- Streaming, each mode, DATA_WIDTH=8: push 0x01..0x10 back-to-back with ready_i=1 -> identical sequence out.
  - BYPASS: same cycle.
  - Others: one cycle later.
  - 16 beats in 16 cycles (FIFO/SPILL/FWD).
- FIFO fill, DEPTH=3 (non-power-of-two), ready_i=0:
  - Push 0xA0,0xA1,0xA2,0xA3 -> ready_o drops after the 3rd beat; usage_o=3; 0xA3 stalls.
  - Then ready_i=1 -> output 0xA0,0xA1,0xA2,0xA3. Pointer wrap exercised over 10 further beats.
- SPILL backpressure: ready_i toggles 1,0,0,1 while pushing 0x11..0x14 every cycle -> ready_o falls to 0 only when usage_o=2; data_o stays stable during stalls; order is preserved.
- Flush: FIFO holding 0xB0,0xB1 (usage_o=2), assert flush_i for 1 cycle with valid_i=1 and ready_i=1 -> no handshake in that cycle. Next cycle usage_o=0 and valid_o=0; the following push 0xC0 emerges next.
- Mid-operation reset: SPILL holding 2 beats, pulse rst_ni low asynchronously between edges -> valid_o=0 and usage_o=0 immediately; no stale beat after release.
